// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller / register watcher.
//   run_state_e : controller FSM states
//   CAUSE_*     : encodings reported on done_cause
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReset,
        StRun,
        StDone
    } run_state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_MATCH  = 2'b10;

endpackage

// File: rtl/run_ctrl_logq.sv
// Change-log queue for the watched channels.
// Each channel has one pending slot (flag + data). The lowest-index pending
// channel is moved into a single output register whenever that register is
// empty or being accepted, giving one entry per cycle under sustained load.
// Ports:
//   clk, rst          clock, async active-high reset
//   chg               per-channel change event this cycle
//   chg_data          new channel values, channel i at [i*DATA_W +: DATA_W]
//   ovf_clr           clears the sticky overflow flags
//   log_ready         consumer accepts the current entry
//   log_valid/ch/data output entry
//   overflow          sticky per-channel "pending change was overwritten"
module run_ctrl_logq #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CH_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        chg,
    input  logic [NUM_CH*DATA_W-1:0] chg_data,
    input  logic                     ovf_clr,
    input  logic                     log_ready,
    output logic                     log_valid,
    output logic [CH_W-1:0]          log_ch,
    output logic [DATA_W-1:0]        log_data,
    output logic [NUM_CH-1:0]        overflow
);

    logic [NUM_CH-1:0]        pend_q, pend_d;
    logic [NUM_CH*DATA_W-1:0] pdata_q, pdata_d;
    logic [NUM_CH-1:0]        ovf_q, ovf_d;
    logic                     valid_q;
    logic [CH_W-1:0]          ch_q;
    logic [DATA_W-1:0]        data_q;

    logic                     take;
    logic [CH_W-1:0]          pick;
    logic [DATA_W-1:0]        pick_data;

    always_comb begin
        pick      = '0;
        pick_data = '0;
        // Descending scan so the lowest pending index wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick      = CH_W'(i);
                pick_data = pdata_q[i*DATA_W +: DATA_W];
            end
        end
        take = (|pend_q) && (!valid_q || log_ready);

        pend_d  = pend_q;
        pdata_d = pdata_q;
        ovf_d   = ovf_clr ? '0 : ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chg[i]) begin
                // A new change refills the slot even if the old value leaves now.
                pend_d[i]                     = 1'b1;
                pdata_d[i*DATA_W +: DATA_W]   = chg_data[i*DATA_W +: DATA_W];
                if (pend_q[i] && !(take && pick == CH_W'(i))) begin
                    ovf_d[i] = 1'b1;
                end
            end else if (take && pick == CH_W'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            pdata_q <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            ovf_q   <= ovf_d;
            if (take) begin
                valid_q <= 1'b1;
                ch_q    <= pick;
                data_q  <= pick_data;
            end else if (log_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign log_valid = valid_q;
    assign log_ch    = ch_q;
    assign log_data  = data_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/run_ctrl_monitor.sv
// Run controller and multi-channel register watcher.
// Sequences the DUT reset, gates DUT execution via run_en, stops on a cycle
// budget or a per-channel value match, and logs every change of the watched
// words through a valid/ready stream.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    run request (honoured in IDLE/DONE)
//   watch_data, match_value  NUM_CH packed words; match_en per channel
//   dut_rst, run_en          DUT reset and clock enable
//   running, done            status; done_cause/match_ch/cycle_count results
//   log_valid/ready/ch/data  change log stream; overflow sticky per channel
module run_ctrl_monitor
    import run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned CH_W       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] watch_data,
    input  logic [NUM_CH*DATA_W-1:0] match_value,
    input  logic [NUM_CH-1:0]        match_en,
    output logic                     dut_rst,
    output logic                     run_en,
    output logic                     running,
    output logic                     done,
    output logic [1:0]               done_cause,
    output logic [CH_W-1:0]          match_ch,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [CH_W-1:0]          log_ch,
    output logic [DATA_W-1:0]        log_data,
    output logic [NUM_CH-1:0]        overflow
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RstW-1:0]  RstLoad = RstW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYCLES - 1);

    run_state_e               state_q, state_d;
    logic [RstW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               cause_q, cause_d;
    logic [CH_W-1:0]          mch_q, mch_d;
    logic                     base_q, base_d;
    logic [NUM_CH*DATA_W-1:0] prev_q;

    logic [NUM_CH-1:0]        hit;
    logic [CH_W-1:0]          hit_ch;
    logic [NUM_CH-1:0]        chg;
    logic                     ovf_clr;

    always_comb begin
        hit_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = match_en[i] &&
                     (watch_data[i*DATA_W +: DATA_W] == match_value[i*DATA_W +: DATA_W]);
            // No change is reported until a baseline has been sampled.
            chg[i] = (state_q == StRun) && base_q &&
                     (watch_data[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) hit_ch = CH_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        mch_d     = mch_q;
        base_d    = base_q;
        ovf_clr   = 1'b0;
        dut_rst   = 1'b0;
        run_en    = 1'b0;
        running   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                dut_rst = 1'b1;
                if (start) begin
                    state_d   = StReset;
                    rst_cnt_d = RstLoad;
                end
            end
            StReset: begin
                dut_rst = 1'b1;
                if (rst_cnt_q == '0) state_d = StRun;
                else                 rst_cnt_d = rst_cnt_q - 1'b1;
            end
            StRun: begin
                run_en  = 1'b1;
                running = 1'b1;
                base_d  = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (|hit) begin
                    state_d = StDone;
                    cause_d = CAUSE_MATCH;
                    mch_d   = hit_ch;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cause_d = CAUSE_BUDGET;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    // Restart keeps undelivered log entries.
                    state_d   = StReset;
                    rst_cnt_d = RstLoad;
                    cnt_d     = '0;
                    cause_d   = CAUSE_NONE;
                    mch_d     = '0;
                    base_d    = 1'b0;
                    ovf_clr   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            cause_q   <= CAUSE_NONE;
            mch_q     <= '0;
            base_q    <= 1'b0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            mch_q     <= mch_d;
            base_q    <= base_d;
            if (state_q == StRun) prev_q <= watch_data;
        end
    end

    assign done_cause  = cause_q;
    assign match_ch    = mch_q;
    assign cycle_count = cnt_q;

    run_ctrl_logq #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_logq (
        .clk       (clk),
        .rst       (rst),
        .chg       (chg),
        .chg_data  (watch_data),
        .ovf_clr   (ovf_clr),
        .log_ready (log_ready),
        .log_valid (log_valid),
        .log_ch    (log_ch),
        .log_data  (log_data),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_run_ctrl_monitor.sv
// Self-checking bench for run_ctrl_monitor with default parameters.
module tb_run_ctrl_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] watch_data;
    logic [127:0] match_value;
    logic [3:0]   match_en;
    logic         dut_rst, run_en, running, done;
    logic [1:0]   done_cause;
    logic [2:0]   match_ch;
    logic [15:0]  cycle_count;
    logic         log_valid, log_ready;
    logic [2:0]   log_ch;
    logic [31:0]  log_data;
    logic [3:0]   overflow;

    int tests = 0;
    int fails = 0;

    run_ctrl_monitor u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .watch_data  (watch_data),
        .match_value (match_value),
        .match_en    (match_en),
        .dut_rst     (dut_rst),
        .run_en      (run_en),
        .running     (running),
        .done        (done),
        .done_cause  (done_cause),
        .match_ch    (match_ch),
        .cycle_count (cycle_count),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_ch      (log_ch),
        .log_data    (log_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        watch_data[ch*32 +: 32] = v;
    endtask

    task automatic set_mv(input int ch, input logic [31:0] v);
        match_value[ch*32 +: 32] = v;
    endtask

    // Pulses start and returns at the first RUN cycle; checks reset length.
    task automatic do_start();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (dut_rst && n < 20) begin
            n++;
            tick();
        end
        chk("rst_len", n, 4);
        chk("run_at_t0", running, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_rst"}, dut_rst, 1);
        chk({tag, "_run_en"}, run_en, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cause"}, done_cause, 0);
        chk({tag, "_match_ch"}, match_ch, 0);
        chk({tag, "_count"}, cycle_count, 0);
        chk({tag, "_log_valid"}, log_valid, 0);
        chk({tag, "_log_ch"}, log_ch, 0);
        chk({tag, "_log_data"}, log_data, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    typedef struct {
        logic [31:0] ch0;
        logic        exp_run;
        logic        exp_done;
        logic        exp_lv;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;

        // ch0 ramp with match on 5: row r drives cycle r, checks after its edge.
        tbl[0] = '{32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{32'd1, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[2] = '{32'd2, 1'b1, 1'b0, 1'b1, 32'd1};
        tbl[3] = '{32'd3, 1'b1, 1'b0, 1'b1, 32'd2};
        tbl[4] = '{32'd4, 1'b1, 1'b0, 1'b1, 32'd3};
        tbl[5] = '{32'd5, 1'b0, 1'b1, 1'b1, 32'd4};
        tbl[6] = '{32'd5, 1'b0, 1'b1, 1'b1, 32'd5};
        tbl[7] = '{32'd5, 1'b0, 1'b1, 1'b0, 32'd0};

        rst         = 1'b1;
        start       = 1'b0;
        watch_data  = '0;
        match_value = '0;
        match_en    = '0;
        log_ready   = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        chk("idle_dut_rst", dut_rst, 1);

        // Budget run.
        do_start();
        n = 0;
        while (run_en && n < 1100) begin
            n++;
            tick();
        end
        chk("budget_run_len", n, 1000);
        chk("budget_done", done, 1);
        chk("budget_cause", done_cause, 2'b01);
        chk("budget_count", cycle_count, 1000);
        chk("budget_log_valid", log_valid, 0);

        // Match on ch0 == 5 with a ramp, table driven.
        watch_data = '0;
        match_en   = 4'b0001;
        set_mv(0, 32'd5);
        do_start();
        for (int r = 0; r < 8; r++) begin
            set_ch(0, tbl[r].ch0);
            tick();
            chk($sformatf("ramp%0d_running", r), running, tbl[r].exp_run);
            chk($sformatf("ramp%0d_done", r), done, tbl[r].exp_done);
            chk($sformatf("ramp%0d_log_valid", r), log_valid, tbl[r].exp_lv);
            if (tbl[r].exp_lv) begin
                chk($sformatf("ramp%0d_log_ch", r), log_ch, 0);
                chk($sformatf("ramp%0d_log_data", r), log_data, tbl[r].exp_data);
            end
        end
        chk("ramp_cause", done_cause, 2'b10);
        chk("ramp_match_ch", match_ch, 0);
        chk("ramp_count", cycle_count, 6);
        match_en = '0;

        // Simultaneous changes on ch1 and ch3.
        watch_data  = '0;
        match_value = '0;
        do_start();
        tick();
        set_ch(1, 32'h11);
        set_ch(3, 32'h33);
        tick();
        chk("pair_lv_early", log_valid, 0);
        tick();
        chk("pair_first_lv", log_valid, 1);
        chk("pair_first_ch", log_ch, 1);
        chk("pair_first_data", log_data, 32'h11);
        tick();
        chk("pair_second_lv", log_valid, 1);
        chk("pair_second_ch", log_ch, 3);
        chk("pair_second_data", log_data, 32'h33);
        tick();
        chk("pair_drained", log_valid, 0);
        chk("pair_overflow", overflow, 0);
        match_en = 4'b0001;
        tick();
        chk("pair_done", done, 1);
        chk("pair_cause", done_cause, 2'b10);
        match_en = '0;

        // Overwrite of a pending ch2 entry while the output is stalled.
        watch_data = '0;
        do_start();
        tick();
        log_ready = 1'b0;
        set_ch(0, 32'h1);
        tick();
        tick();
        chk("ovf_hold_lv", log_valid, 1);
        chk("ovf_hold_ch", log_ch, 0);
        set_ch(2, 32'hA);
        tick();
        set_ch(2, 32'hB);
        tick();
        chk("ovf_flag", overflow, 4'b0100);
        chk("ovf_stable_ch", log_ch, 0);
        chk("ovf_stable_data", log_data, 32'h1);
        log_ready = 1'b1;
        tick();
        chk("ovf_entry_lv", log_valid, 1);
        chk("ovf_entry_ch", log_ch, 2);
        chk("ovf_entry_data", log_data, 32'hB);
        tick();
        chk("ovf_drained", log_valid, 0);
        match_en = 4'b0001;
        set_mv(0, 32'h1);
        tick();
        chk("ovf_done", done, 1);
        match_en = '0;

        // Match on ch0 and ch2 in the budget's last cycle.
        watch_data  = '0;
        match_value = '0;
        set_mv(0, 32'h77);
        set_mv(2, 32'h99);
        match_en = 4'b0101;
        do_start();
        chk("restart_overflow_clr", overflow, 0);
        n = 0;
        while (cycle_count != 16'd999 && n < 1100) begin
            n++;
            tick();
        end
        chk("last_count", cycle_count, 999);
        chk("last_running", running, 1);
        set_ch(0, 32'h77);
        set_ch(2, 32'h99);
        tick();
        chk("last_done", done, 1);
        chk("last_cause", done_cause, 2'b10);
        chk("last_match_ch", match_ch, 0);
        chk("last_final_count", cycle_count, 1000);
        tick();
        chk("last_log0_ch", log_ch, 0);
        chk("last_log0_data", log_data, 32'h77);
        tick();
        chk("last_log1_ch", log_ch, 2);
        chk("last_log1_data", log_data, 32'h99);
        tick();
        chk("last_drained", log_valid, 0);
        match_en = '0;

        // Reset in the middle of RUN with entries pending.
        watch_data = '0;
        do_start();
        tick();
        log_ready = 1'b0;
        set_ch(1, 32'h5);
        set_ch(3, 32'h6);
        tick();
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        log_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_no_log", log_valid, 0);
        chk("midrst_idle", dut_rst, 1);
        do_start();
        chk("midrst_count0", cycle_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
